// File: rtl/divider.sv
// divider: 64-bit restoring divider for the DIV/DIVU/REM/REMU and W variants, IDLE/BUSY/DONE handshake.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed-overflow cases one cycle after acceptance.
module divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c
);
  localparam int HW = WIDTH / 2;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [6:0] r_cnt;
  logic [2:0] r_op;
  logic [WIDTH-1:0] r_a, r_b, r_quo, r_rem;
  logic [WIDTH-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_q, w_r, w_res;
  logic [WIDTH:0] w_shift, w_diff;
  logic w_signed, w_word, w_accept, w_early, w_r_signed;
  assign w_signed = !op[0];
  assign w_word   = op[2];
  assign w_a_ext  = !w_word ? a : {{HW{w_signed & a[HW-1]}}, a[HW-1:0]};
  assign w_b_ext  = !w_word ? b : {{HW{w_signed & b[HW-1]}}, b[HW-1:0]};
  assign w_a_mag  = (w_signed && w_a_ext[WIDTH-1]) ? -w_a_ext : w_a_ext;
  assign w_accept = in_valid && r_state == IDLE && !flush;
`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_b_ext == '0) || (w_signed && (w_word ?
                   (a[HW-1:0] == {1'b1, {(HW-1){1'b0}}} && b[HW-1:0] == '1) :
                   (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1)));
`else
  assign w_early = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (flush) w_next = IDLE;
    else if (r_state == IDLE && in_valid) w_next = w_early ? DONE : BUSY;
    else if (r_state == BUSY && r_cnt == 7'(WIDTH - 1)) w_next = DONE;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end
  // r_quo starts as the dividend magnitude and fills with quotient bits from the LSB
  assign w_r_signed = !r_op[0];
  assign w_b_mag    = (w_r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, w_b_mag};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_quo <= '0;
      r_rem <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_op  <= op;
      r_a   <= w_a_ext;
      r_b   <= w_b_ext;
      r_quo <= w_a_mag;
      r_rem <= '0;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + 7'd1;
      r_quo <= {r_quo[WIDTH-2:0], !w_diff[WIDTH]};
      r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end
  // signed overflow needs no override: |min|/1 negated wraps back to min with remainder 0
  assign w_q   = (w_r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -r_quo : r_quo;
  assign w_r   = (w_r_signed && r_a[WIDTH-1]) ? -r_rem : r_rem;
  assign w_res = (r_b == '0) ? (r_op[1] ? r_a : '1) : (r_op[1] ? w_r : w_q);
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign c = !out_valid ? '0 : r_op[2] ? {{HW{w_res[HW-1]}}, w_res[HW-1:0]} : w_res;
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed vector table plus hand sequences for backpressure, flush and reset on divider.
module tb_divider;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [63:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic in_ready, out_valid;
  logic [63:0] c;
  int checks = 0, errors = 0;
`ifdef DIV_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 65;
`endif
  typedef struct {
    string nm;
    logic [2:0] op;
    logic [63:0] a, b, c;
    bit sp;
  } vec_t;
  vec_t vecs[$];
  divider #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .c(c)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_valid(input string nm, output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL %s: out_valid timeout got 0 expected 1", nm);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    in_valid = 1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 0;
    a = '1;
    b = '1;
  endtask
  task automatic run(input string nm, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                     input int lat_exp, input logic [63:0] c_exp);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready"}, {63'b0, in_ready}, 64'd1);
    issue(o, x, y);
    wait_valid(nm, lat);
    chk({nm, " latency"}, 64'(lat), 64'(lat_exp));
    chk({nm, " c"}, c, c_exp);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({nm, " in_ready after consume"}, {63'b0, in_ready}, 64'd1);
    chk({nm, " out_valid after consume"}, {63'b0, out_valid}, 64'd0);
  endtask
  initial begin
    int lat;
    bit seen;
    vecs.push_back('{"divu 100/7", 3'd1, 64'd100, 64'd7, 64'd14, 1'b0});
    vecs.push_back('{"remu 100/7", 3'd3, 64'd100, 64'd7, 64'd2, 1'b0});
    vecs.push_back('{"div -7/2", 3'd0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    vecs.push_back('{"rem -7/2", 3'd2, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"div 7/-2", 3'd0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    vecs.push_back('{"rem 7/-2", 3'd2, 64'd7, -64'sd2, 64'd1, 1'b0});
    vecs.push_back('{"divu max/16", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"remu max/16", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'd15, 1'b0});
    vecs.push_back('{"divu min/max", 3'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0});
    vecs.push_back('{"divw -7/2", 3'd4, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    vecs.push_back('{"divuw", 3'd5, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b0});
    vecs.push_back('{"divuw sext", 3'd5, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"remuw", 3'd7, 64'hABCD_0000_FFFF_FFFF, 64'd16, 64'd15, 1'b0});
    vecs.push_back('{"div 5/0", 3'd0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{"remu 5/0", 3'd3, 64'd5, 64'd0, 64'd5, 1'b1});
    vecs.push_back('{"remw x/0", 3'd6, 64'h0000_0001_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b1});
    vecs.push_back('{"remuw x/0", 3'd7, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b1});
    vecs.push_back('{"divuw x/0", 3'd5, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{"divw ovf", 3'd4, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1});
    vecs.push_back('{"remw ovf", 3'd6, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1});
    vecs.push_back('{"div ovf", 3'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1});
    vecs.push_back('{"rem ovf", 3'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1});
    #12;
    chk("reset in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset c", c, 64'd0);
    @(negedge clk);
    reset = 1;
    foreach (vecs[i]) run(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sp ? SP_LAT : 65, vecs[i].c);
    issue(3'd1, 64'd100, 64'd7);
    wait_valid("hold", lat);
    repeat (10) begin
      @(negedge clk);
      chk("hold out_valid", {63'b0, out_valid}, 64'd1);
      chk("hold c", c, 64'd14);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("hold consumed", {63'b0, in_ready}, 64'd1);
    issue(3'd1, 64'd100, 64'd7);
    repeat (29) @(negedge clk);
    chk("busy c zero", c, 64'd0);
    chk("busy in_ready", {63'b0, in_ready}, 64'd0);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush in_ready", {63'b0, in_ready}, 64'd1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush no result", {63'b0, seen}, 64'd0);
    @(negedge clk);
    in_valid = 1;
    flush = 1;
    op = 3'd1;
    a = 64'd8;
    b = 64'd2;
    @(negedge clk);
    in_valid = 0;
    flush = 0;
    chk("flush beats accept", {63'b0, in_ready}, 64'd1);
    issue(3'd1, 64'd8, 64'd2);
    wait_valid("flush done", lat);
    flush = 1;
    out_ready = 1;
    @(negedge clk);
    flush = 0;
    out_ready = 0;
    chk("flush done out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush done in_ready", {63'b0, in_ready}, 64'd1);
    issue(3'd1, 64'd1000, 64'd3);
    repeat (19) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("mid reset in_ready", {63'b0, in_ready}, 64'd1);
    chk("mid reset out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid reset c", c, 64'd0);
    @(negedge clk);
    reset = 1;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("mid reset no result", {63'b0, seen}, 64'd0);
    run("divu 9/3", 3'd1, 64'd9, 64'd3, 65, 64'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
